// File: rtl/parity_serializer.sv
// Parallel-to-serial transmitter: sends a word LSB first over DATA_W cycles,
// followed by one parity bit so the frame has even (or odd) total ones.
module parity_serializer #(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  output logic              sout,
  output logic              sout_valid,
  output logic              sout_par,
  output logic              frame_done
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next, shift_shr;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              par_reg, par_next;
  logic              sout_reg, sout_next;
  logic              valid_reg, valid_next;
  logic              spar_reg, spar_next;
  logic              done_reg, done_next;
  logic              accept;

  // shift_reg holds only the bits not yet presented on sout
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W - 1; gi++) begin : g_shr
      assign shift_shr[gi] = shift_reg[gi+1];
    end
  endgenerate
  assign shift_shr[DATA_W-1] = 1'b0;

  assign ready  = (state_reg != SHIFT);
  assign accept = load && ready;

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    par_next   = par_reg;
    sout_next  = 1'b0;
    valid_next = 1'b0;
    spar_next  = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      SHIFT: begin
        valid_next = 1'b1;
        if (cnt_reg == LAST_BIT) begin
          state_next = PARITY;
          sout_next  = par_reg;
          spar_next  = 1'b1;
          done_next  = 1'b1;
        end else begin
          cnt_next   = cnt_reg + CNT_W'(1);
          sout_next  = shift_reg[0];
          shift_next = shift_shr;
        end
      end
      default: begin
        // IDLE and PARITY both accept; PARITY -> SHIFT gives back-to-back frames
        if (accept) begin
          state_next = SHIFT;
          shift_next = data_in >> 1;
          cnt_next   = '0;
          par_next   = (^data_in) ^ ODD_PARITY;
          sout_next  = data_in[0];
          valid_next = 1'b1;
        end else begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
      par_reg   <= 1'b0;
      sout_reg  <= 1'b0;
      valid_reg <= 1'b0;
      spar_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
      par_reg   <= par_next;
      sout_reg  <= sout_next;
      valid_reg <= valid_next;
      spar_reg  <= spar_next;
      done_reg  <= done_next;
    end
  end

  assign sout       = sout_reg;
  assign sout_valid = valid_reg;
  assign sout_par   = spar_reg;
  assign frame_done = done_reg;

endmodule

// File: tb/tb_parity_serializer.sv
// Scoreboard bench: an even and an odd instance share stimulus; expected
// frame bits are queued at accept time and checked by a negedge monitor.
module tb_parity_serializer;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] data_in;
  logic         load;
  logic         ready_e, sout_e, valid_e, par_e, done_e;
  logic         ready_o, sout_o, valid_o, par_o, done_o;

  parity_serializer #(.DATA_W(W), .ODD_PARITY(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load),
    .ready(ready_e), .sout(sout_e), .sout_valid(valid_e),
    .sout_par(par_e), .frame_done(done_e)
  );

  parity_serializer #(.DATA_W(W), .ODD_PARITY(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load),
    .ready(ready_o), .sout(sout_o), .sout_valid(valid_o),
    .sout_par(par_o), .frame_done(done_o)
  );

  typedef struct {
    int cyc;
    bit be;
    bit bo;
    bit par;
  } exp_t;

  exp_t q[$];
  bit   busy[int];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus; the model decides acceptance from its own busy map.
  task automatic step(input bit ld, input logic [W-1:0] d);
    int c;
    int ones;
    bit pe;
    exp_t e;
    load = ld;
    data_in = d;
    c = cyc;
    if (ld && rst_n && !busy.exists(c)) begin
      ones = $countones(d);
      pe = bit'(ones % 2);
      for (int i = 0; i < W; i++) begin
        e.cyc = c + 1 + i;
        e.be = bit'((d >> i) & 1);
        e.bo = e.be;
        e.par = 1'b0;
        q.push_back(e);
        busy[c + 1 + i] = 1'b1;
      end
      e.cyc = c + 1 + W;
      e.be = pe;
      e.bo = !pe;
      e.par = 1'b1;
      q.push_back(e);
      $display("load accepted cycle %0d data=%02h even_par=%0b odd_par=%0b", c, d, pe, !pe);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    load = 1'b0;
    q.delete();
    busy.delete();
    #1;
    chk("rst_async_valid_e", 32'(valid_e), 32'd0);
    chk("rst_async_valid_o", 32'(valid_o), 32'd0);
    chk("rst_async_sout_e", 32'(sout_e), 32'd0);
    chk("rst_async_done_o", 32'(done_o), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("reset pulse released cycle %0d", cyc);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    chk("ready_e", 32'(ready_e), 32'(!busy.exists(cyc)));
    chk("ready_o", 32'(ready_o), 32'(!busy.exists(cyc)));
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      chk("missed_bit_cycle", 32'(cyc), 32'(e.cyc));
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("valid_e", 32'(valid_e), 32'd1);
      chk("valid_o", 32'(valid_o), 32'd1);
      chk("sout_e", 32'(sout_e), 32'(e.be));
      chk("sout_o", 32'(sout_o), 32'(e.bo));
      chk("par_e", 32'(par_e), 32'(e.par));
      chk("par_o", 32'(par_o), 32'(e.par));
      chk("done_e", 32'(done_e), 32'(e.par));
      chk("done_o", 32'(done_o), 32'(e.par));
      if (e.par)
        $display("frame end cycle %0d parity even=%0b odd=%0b", cyc, sout_e, sout_o);
    end else begin
      chk("idle_valid_e", 32'(valid_e), 32'd0);
      chk("idle_valid_o", 32'(valid_o), 32'd0);
      chk("idle_sout_e", 32'(sout_e), 32'd0);
      chk("idle_sout_o", 32'(sout_o), 32'd0);
      chk("idle_par", 32'({par_e, par_o}), 32'd0);
      chk("idle_done", 32'({done_e, done_o}), 32'd0);
    end
  end

  initial begin
    rst_n = 1'b0;
    load = 1'b0;
    data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 8'h00);
    step(1'b0, 8'h5A);

    // even/odd single frames
    step(1'b1, 8'hA5);
    repeat (10) step(1'b0, W'($urandom));
    step(1'b1, 8'h07);
    repeat (10) step(1'b0, W'($urandom));

    // back-to-back: load during the parity cycle
    step(1'b1, 8'hA5);
    repeat (8) step(1'b0, W'($urandom));
    step(1'b1, 8'hFF);
    repeat (10) step(1'b0, W'($urandom));

    // load while shifting is ignored
    step(1'b1, 8'hA5);
    step(1'b0, 8'h11);
    step(1'b0, 8'h22);
    step(1'b1, 8'h00);
    repeat (10) step(1'b0, W'($urandom));

    // reset in cycle 4 of a frame, then a fresh frame
    step(1'b1, 8'h5A);
    repeat (3) step(1'b0, W'($urandom));
    mid_reset();
    step(1'b1, 8'h3C);
    repeat (10) step(1'b0, W'($urandom));

    // randomized traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0)
        mid_reset();
      else
        step(bit'($urandom_range(0, 1)), W'($urandom));
    end

    repeat (12) step(1'b0, W'($urandom));
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parity_serializer.md
Name: parity_serializer

Overview:
- Transmit-side companion to the team's serial parity checker.
- Accepts a parallel word through a valid/ready handshake and shifts it out serially, LSB first, one bit per clock.
- Appends one parity bit after the data bits, so a downstream running-parity checker sees a parity-consistent frame.
- Sits between a parallel data source and the single-bit serial link.

Parameters:
- DATA_W, 8, data bits per frame; legal range 2..32.
- ODD_PARITY, 0, 0 = even parity (total ones in data+parity even), 1 = odd parity.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- data_in  input  DATA_W  parallel word to send
- load  input  1  word valid; accepted on a rising edge where load && ready
- ready  output  1  block can accept a word this cycle
- sout  output  1  serial bit (registered)
- sout_valid  output  1  sout carries a frame bit this cycle
- sout_par  output  1  current sout bit is the parity bit
- frame_done  output  1  one-cycle pulse, concurrent with the parity bit

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, shift register=0, bit counter=0.
  - sout=0, sout_valid=0, sout_par=0, frame_done=0.
  - ready=1 in the first cycle after release.
- States:
  - IDLE: ready=1; sout_valid=0; sout=0.
  - SHIFT: ready=0; outputs data bits 0..DATA_W-1, LSB first; the counter counts 0..DATA_W-1.
  - PARITY: ready=1; sout=parity, sout_valid=1, sout_par=1, frame_done=1.
- Parity value:
  - Even parity: parity = XOR-reduction of the captured word.
  - Odd parity: parity = inverse of that XOR-reduction.
  - Latch parity at accept time, not from the live data_in.
- Transitions:
  - IDLE: load && ready -> SHIFT. Capture data_in at that edge and present bit0 on sout from that edge on.
  - SHIFT: when counter == DATA_W-1 -> PARITY; otherwise shift right and increment the counter.
  - PARITY: load -> SHIFT with the new word's bit0 (back-to-back, no gap); otherwise -> IDLE.
- Latency:
  - Accept at edge k puts bit0 valid in cycle k+1 and the parity bit in cycle k+1+DATA_W.
  - Frame length is DATA_W+1 cycles.
  - Sustained throughput is one word per DATA_W+1 cycles.
- Handshake:
  - load while ready=0 (SHIFT) is ignored; no queuing.
  - data_in is sampled only at the accept edge; later changes have no effect.
- sout, sout_valid and sout_par are all registered; no combinational path from inputs to outputs.
- When sout_valid=0, sout is forced to 0.
- Reset mid-frame aborts the frame immediately: outputs go to 0 asynchronously and no partial parity bit is emitted.
- Consistency with the checker:
  - Even mode: the checker's output after the parity bit is 0.
  - Odd mode: that output is 1.
  - This holds only if the checker's state is cleared at the frame start.
- Counter width: $clog2(DATA_W), minimum 1 bit. The wrap from DATA_W-1 is handled by the state change, not by overflow.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release -> ready=1, sout=0, sout_valid=0, sout_par=0, frame_done=0.
- Even frame: DATA_W=8, ODD_PARITY=0, load 8'hA5 -> sout=1,0,1,0,0,1,0,1 over cycles 1-8, then parity 0 in cycle 9 with sout_par=1 and frame_done=1; ready=0 in cycles 1-8.
- Odd frame: ODD_PARITY=1, load 8'h07 -> sout=1,1,1,0,0,0,0,0, then parity 0. With ODD_PARITY=0 the parity bit is 1.
- Back-to-back: assert load with 8'hFF during the parity cycle of the previous frame -> the next cycle shows bit0=1 with sout_valid staying high; the 8'hFF parity bit is 0 (even).
- Ignored load: pulse load with 8'h00 in cycle 3 of a 8'hA5 frame -> the frame bits are unchanged and no extra frame follows.
- Mid-frame reset: drop rst_n in cycle 4 of a frame -> sout_valid=0 at once. After release, ready=1 and a fresh 8'h3C frame sends 0,0,1,1,1,1,0,0, then parity 0.
